mcpu_mem_responder: RTL and testbench
=====================================

Name: mcpu_mem_responder

Overview:
- Memory-side responder for the multi-cycle CPU's control FSM.
- Services the read/write strobes, address-select and size code (lwsh) issued by the controller.
- Performs byte/halfword lane selection, sign extension and read-modify-write against a word-wide synchronous single-port RAM.
- Returns a one-cycle ready pulse with formatted read data.
- Sits between the datapath's memory address/data registers and the RAM macro.

Parameters:
- DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words; ram_addr width.
- WAIT_CYC, 0, extra wait states (0..15) inserted after accept, before any RAM access.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_read  in  1  read request, level; sampled only in IDLE.
- mem_write  in  1  write request, level; sampled only in IDLE.
- lwsh  in  2  size code: 00 word, 01 byte, 10 half, 11 treated as word.
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified for byte/half.
- rdata  out  32  formatted load data; valid while ready=1.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  high in every state except IDLE.
- misalign_err  out  1  high with ready when the request was misaligned.
- ram_en  out  1  RAM access enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  DEPTH_LOG2  RAM word address = addr_q[DEPTH_LOG2+1:2].
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid one cycle after ram_en with ram_we=0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, wait counter=0.
  - rdata=0, ready=0, misalign_err=0.
  - ram_en=0, ram_we=0; all latched request registers 0.
  - Reset mid-transaction aborts it and drops ram_we immediately.
  - No ready is produced for the aborted request.
- States: IDLE, WAIT, RD, CAP, WR, RMW_RD, RMW_CAP, RMW_WR, DONE.
  - ram_en/ram_we are combinational from state.
  - ready, rdata, misalign_err are registered.
- Accept:
  - In IDLE, if mem_read|mem_write, latch addr_q, wdata_q, size_q, dir_q.
  - mem_write has priority when both are asserted.
  - Requests outside IDLE are ignored.
- Misalignment check at accept:
  - Half with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
  - A misaligned request goes straight to DONE with misalign_err=1, rdata=0, and no RAM access.
- WAIT: entered only if WAIT_CYC>0; holds exactly WAIT_CYC cycles, then proceeds to the access state.
- Read path:
  - RD: ram_en=1, ram_we=0.
  - CAP: data is formatted from ram_rdata, then DONE.
  - Byte lane = addr_q[1:0], little-endian: lane 0 = bits 7:0.
  - Half lane = addr_q[1]: 0 → bits 15:0.
  - Byte/half results are sign-extended to 32 bits.
- Word write: WR (ram_en=1, ram_we=1, ram_wdata=wdata_q), then DONE.
- Byte/half write:
  - RMW_RD issues a read.
  - RMW_CAP merges wdata_q[7:0] or [15:0] into the addressed lane of ram_rdata, storing the result in a merge register.
  - RMW_WR writes the merge register; other lanes are preserved.
- DONE: ready=1 for exactly one cycle; rdata holds its value until the next DONE; then IDLE.
- Latency, counted in edges from the accept edge, with W=WAIT_CYC:
  - Read: 3+W.
  - Word write: 2+W.
  - Sub-word write: 4+W.
  - Misaligned: 1.
  - In each case ready is high in the cycle following that edge count.
- Back-to-back: a new request can be accepted on the edge that leaves DONE→IDLE+1; the minimum gap is one IDLE cycle.
- busy=1 from the accept edge until return to IDLE.

Test Plan:
- Preload word 4 = 0x80FF7F01; lb at addr 0x10..0x13 → rdata 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; each ready 3 edges after accept (WAIT_CYC=0).
- Same word: lh at 0x10 → 0x00007F01, lh at 0x12 → 0xFFFF80FF; lw at 0x10 → 0x80FF7F01.
- sb wdata=0xAB at 0x11 on 0x11223344 → RAM word 0x1122AB44; sh 0xBEEF at 0x12 → 0xBEEFAB44; ready 4 edges after accept; exactly one ram_we cycle each.
- lw at 0x02 and lh at 0x03 → ready+misalign_err after 1 edge, rdata=0, ram_en never asserted.
- WAIT_CYC=3, sw 0xDEADBEEF at 0x20 → ram_we at word 8 after 3 wait cycles, ready at edge 5; mem_read pulses during busy are ignored.
- Assert rst_n=0 during RMW_RD of an sb → ram_we stays 0, RAM word unchanged, no ready; after release, a fresh lw completes normally.

Source files
------------

// File: rtl/mcpu_mem_responder_if.sv
// mcpu_mem_responder_if
//   CPU-side bus between the multi-cycle controller and the memory responder.
//   master: controller (drives requests, receives completion)
//   slave : responder  (receives requests, drives completion)
//   Signals:
//     mem_read, mem_write  level request strobes, sampled only while the responder is idle
//     lwsh                 size code: 00 word, 01 byte, 10 half, 11 word
//     addr                 byte address
//     wdata                store data, right-justified for byte/half
//     rdata                formatted load data, valid while ready=1
//     ready                one-cycle completion pulse
//     busy                 responder is not idle
//     misalign_err         accompanies ready when the request was misaligned
interface mcpu_mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  lwsh;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        misalign_err;

  modport master (
    output mem_read, mem_write, lwsh, addr, wdata,
    input  rdata, ready, busy, misalign_err
  );

  modport slave (
    input  mem_read, mem_write, lwsh, addr, wdata,
    output rdata, ready, busy, misalign_err
  );
endinterface

// File: rtl/mcpu_mem_responder.sv
// mcpu_mem_responder
//   Memory-side responder for the multi-cycle CPU. Accepts a read/write
//   request from the controller, optionally inserts wait states, performs
//   byte/half lane selection with sign extension on loads and a
//   read-modify-write on sub-word stores, and returns a one-cycle ready pulse.
//   Ports:
//     clk, rst_n       clock (rising edge), asynchronous active-low reset
//     bus (slave)      controller request/completion bus
//     ram_en, ram_we   RAM access / write enables (decoded from state)
//     ram_addr         RAM word address
//     ram_wdata        RAM write data
//     ram_rdata        RAM read data, valid one cycle after a read access
//   Parameters:
//     DEPTH_LOG2       log2 of RAM depth in 32-bit words
//     WAIT_CYC         wait states (0..15) inserted after accept
module mcpu_mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned WAIT_CYC   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mcpu_mem_responder_if.slave   bus,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [DEPTH_LOG2-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_WAIT    = 4'd1;
  localparam logic [3:0] S_RD      = 4'd2;
  localparam logic [3:0] S_CAP     = 4'd3;
  localparam logic [3:0] S_WR      = 4'd4;
  localparam logic [3:0] S_RMW_RD  = 4'd5;
  localparam logic [3:0] S_RMW_CAP = 4'd6;
  localparam logic [3:0] S_RMW_WR  = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;

  // Counter is loaded with WAIT_CYC-1 so WAIT lasts exactly WAIT_CYC cycles.
  localparam int unsigned WAIT_LOAD = (WAIT_CYC > 0) ? WAIT_CYC - 1 : 0;

  logic [3:0]  state;
  logic [3:0]  wait_cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        dir_q;      // 1 = write
  logic        mis_q;
  logic [31:0] res_q;      // formatted load result, published at DONE
  logic [31:0] merge_q;    // sub-word store merged into the read word

  logic        acc_mis;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_fmt;
  logic [31:0] merged;
  logic        addr_hi_unused;

  // First RAM-access state for a request of the given direction and size.
  function automatic logic [3:0] access_state(input logic wr, input logic [1:0] sz);
    if (!wr)
      return S_RD;
    else if (sz == SZ_BYTE || sz == SZ_HALF)
      return S_RMW_RD;
    else
      return S_WR;
  endfunction

  always_comb begin
    unique case (bus.lwsh)
      SZ_BYTE: acc_mis = 1'b0;
      SZ_HALF: acc_mis = bus.addr[0];
      default: acc_mis = |bus.addr[1:0];
    endcase
  end

  always_comb begin
    byte_sel = ram_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = ram_rdata[{addr_q[1], 4'b0000} +: 16];
    unique case (size_q)
      SZ_BYTE: load_fmt = {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: load_fmt = {{16{half_sel[15]}}, half_sel};
      default: load_fmt = ram_rdata;
    endcase
  end

  always_comb begin
    merged = ram_rdata;
    if (size_q == SZ_BYTE)
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      wait_cnt         <= '0;
      addr_q           <= '0;
      wdata_q          <= '0;
      size_q           <= '0;
      dir_q            <= 1'b0;
      mis_q            <= 1'b0;
      res_q            <= '0;
      merge_q          <= '0;
      bus.rdata        <= '0;
      bus.ready        <= 1'b0;
      bus.misalign_err <= 1'b0;
    end else begin
      bus.ready        <= 1'b0;
      bus.misalign_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.mem_read || bus.mem_write) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            size_q  <= bus.lwsh;
            dir_q   <= bus.mem_write;
            mis_q   <= acc_mis;
            res_q   <= '0;
            if (acc_mis) begin
              state <= S_DONE;
            end else if (WAIT_CYC > 0) begin
              state    <= S_WAIT;
              wait_cnt <= 4'(WAIT_LOAD);
            end else begin
              state <= access_state(bus.mem_write, bus.lwsh);
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == '0)
            state <= access_state(dir_q, size_q);
          else
            wait_cnt <= wait_cnt - 4'd1;
        end
        S_RD:      state <= S_CAP;
        S_CAP: begin
          res_q <= load_fmt;
          state <= S_DONE;
        end
        S_WR:      state <= S_DONE;
        S_RMW_RD:  state <= S_RMW_CAP;
        S_RMW_CAP: begin
          merge_q <= merged;
          state   <= S_RMW_WR;
        end
        S_RMW_WR:  state <= S_DONE;
        S_DONE: begin
          bus.ready        <= 1'b1;
          bus.rdata        <= res_q;
          bus.misalign_err <= mis_q;
          state            <= S_IDLE;
        end
        default:   state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ram_en = (state == S_RD) || (state == S_WR) ||
             (state == S_RMW_RD) || (state == S_RMW_WR);
    ram_we = (state == S_WR) || (state == S_RMW_WR);
  end

  assign ram_addr       = addr_q[DEPTH_LOG2+1:2];
  assign ram_wdata      = (state == S_RMW_WR) ? merge_q : wdata_q;
  assign bus.busy       = (state != S_IDLE);
  assign addr_hi_unused = ^addr_q[31:DEPTH_LOG2+2];

endmodule

// File: tb/tb_mcpu_mem_responder.sv
// tb_mcpu_mem_responder
//   Drives two responders (WAIT_CYC=0 and WAIT_CYC=3) with identical requests,
//   each attached to its own synchronous RAM, and compares results, latency,
//   RAM activity and RAM contents against a word-array reference model.
module tb_mcpu_mem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mcpu_mem_responder_if bus0();
  mcpu_mem_responder_if bus3();

  logic        ram_en0, ram_we0, ram_en3, ram_we3;
  logic [9:0]  ram_addr0, ram_addr3;
  logic [31:0] ram_wdata0, ram_wdata3, ram_rdata0, ram_rdata3;

  mcpu_mem_responder #(.DEPTH_LOG2(10), .WAIT_CYC(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .ram_en(ram_en0), .ram_we(ram_we0), .ram_addr(ram_addr0),
    .ram_wdata(ram_wdata0), .ram_rdata(ram_rdata0)
  );

  mcpu_mem_responder #(.DEPTH_LOG2(10), .WAIT_CYC(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3),
    .ram_en(ram_en3), .ram_we(ram_we3), .ram_addr(ram_addr3),
    .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3)
  );

  logic [31:0] mem0 [0:1023];
  logic [31:0] mem3 [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        pre_en = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_en) mem0[pre_addr] <= pre_data;
    else if (ram_en0) begin
      if (ram_we0) mem0[ram_addr0] <= ram_wdata0;
      else         ram_rdata0 <= mem0[ram_addr0];
    end
  end

  always @(posedge clk) begin
    if (pre_en) mem3[pre_addr] <= pre_data;
    else if (ram_en3) begin
      if (ram_we3) mem3[ram_addr3] <= ram_wdata3;
      else         ram_rdata3 <= mem3[ram_addr3];
    end
  end

  int en0 = 0, we0 = 0, rdy0 = 0, en3 = 0, we3 = 0, rdy3 = 0;
  always @(negedge clk) begin
    if (ram_en0)    en0++;
    if (ram_we0)    we0++;
    if (bus0.ready) rdy0++;
    if (ram_en3)    en3++;
    if (ram_we3)    we3++;
    if (bus3.ready) rdy3++;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    bus0.mem_read = rd; bus0.mem_write = wr; bus0.lwsh = sz; bus0.addr = a; bus0.wdata = wd;
    bus3.mem_read = rd; bus3.mem_write = wr; bus3.lwsh = sz; bus3.addr = a; bus3.wdata = wd;
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = 10'(idx); pre_data = d;
    ref_mem[idx] = d;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  // One request issued to both responders; model computed from the size rules.
  task automatic txn(input logic rd, input logic wr, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] wd, input bit pulse_rd);
    int          widx, lat0, lat3, exp_lat, exp_lat3, exp_en, exp_we, sh;
    int          e0s, w0s, r0s, e3s, w3s, r3s;
    bit          mis;
    logic [31:0] word, exp_data, mask, got0, got3;
    logic        me0, me3;

    widx = int'((a >> 2) & 32'd1023);
    word = ref_mem[widx];
    if (sz == 2'b10)      mis = a[0];
    else if (sz == 2'b01) mis = 1'b0;
    else                  mis = (a[1:0] != 2'b00);
    exp_data = 32'h0;
    if (mis) begin
      exp_lat = 1; exp_en = 0; exp_we = 0;
    end else if (!wr) begin
      exp_lat = 3; exp_en = 1; exp_we = 0;
      if (sz == 2'b01) begin
        exp_data = (word >> (8 * int'(a[1:0]))) & 32'hFF;
        if (exp_data >= 32'h80) exp_data = exp_data | 32'hFFFF_FF00;
      end else if (sz == 2'b10) begin
        exp_data = (word >> (16 * int'(a[1]))) & 32'hFFFF;
        if (exp_data >= 32'h8000) exp_data = exp_data | 32'hFFFF_0000;
      end else begin
        exp_data = word;
      end
    end else if (sz == 2'b01 || sz == 2'b10) begin
      exp_lat = 4; exp_en = 2; exp_we = 1;
      sh   = (sz == 2'b01) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
      mask = ((sz == 2'b01) ? 32'hFF : 32'hFFFF) << sh;
      ref_mem[widx] = (word & ~mask) | ((wd << sh) & mask);
    end else begin
      exp_lat = 2; exp_en = 1; exp_we = 1;
      ref_mem[widx] = wd;
    end
    exp_lat3 = mis ? 1 : exp_lat + 3;

    e0s = en0; w0s = we0; r0s = rdy0; e3s = en3; w3s = we3; r3s = rdy3;
    @(negedge clk);
    drive(rd, wr, sz, a, wd);
    @(posedge clk);
    #1;
    chk("busy0_after_accept", {31'b0, bus0.busy}, 32'd1);
    drive(pulse_rd, 1'b0, 2'b00, 32'h0, 32'h0);
    lat0 = 0; lat3 = 0; got0 = '0; got3 = '0; me0 = 1'b0; me3 = 1'b0;
    for (int k = 1; k <= 40 && (lat0 == 0 || lat3 == 0); k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin bus0.mem_read = 1'b0; bus3.mem_read = 1'b0; end
      if (bus0.ready && lat0 == 0) begin lat0 = k; got0 = bus0.rdata; me0 = bus0.misalign_err; end
      if (bus3.ready && lat3 == 0) begin lat3 = k; got3 = bus3.rdata; me3 = bus3.misalign_err; end
    end
    repeat (2) @(posedge clk);
    #1;
    chk("latency_w0", 32'(lat0), 32'(exp_lat));
    chk("latency_w3", 32'(lat3), 32'(exp_lat3));
    chk("ready_pulses_w0", 32'(rdy0 - r0s), 32'd1);
    chk("ready_pulses_w3", 32'(rdy3 - r3s), 32'd1);
    chk("misalign_w0", {31'b0, me0}, {31'b0, mis});
    chk("misalign_w3", {31'b0, me3}, {31'b0, mis});
    chk("ram_en_cycles_w0", 32'(en0 - e0s), 32'(exp_en));
    chk("ram_en_cycles_w3", 32'(en3 - e3s), 32'(exp_en));
    chk("ram_we_cycles_w0", 32'(we0 - w0s), 32'(exp_we));
    chk("ram_we_cycles_w3", 32'(we3 - w3s), 32'(exp_we));
    if (!wr || mis) begin
      chk("rdata_w0", got0, exp_data);
      chk("rdata_w3", got3, exp_data);
    end
    chk("ram_word_w0", mem0[widx], ref_mem[widx]);
    chk("ram_word_w3", mem3[widx], ref_mem[widx]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        rd, wr;
    logic [1:0]  sz;
    logic [31:0] a, hi;
    int          r0s, r3s, w0s, w3s;

    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_ready", {31'b0, bus0.ready}, 32'd0);
    chk("reset_rdata", bus0.rdata, 32'h0);
    chk("reset_misalign", {31'b0, bus0.misalign_err}, 32'd0);
    chk("reset_busy", {31'b0, bus0.busy}, 32'd0);
    chk("reset_ram_en", {31'b0, ram_en0}, 32'd0);
    chk("reset_ram_we", {31'b0, ram_we3}, 32'd0);

    for (int i = 0; i < 64; i++) preload(i, $urandom());
    preload(4, 32'h80FF_7F01);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    // Loads from word 4
    for (int i = 0; i < 4; i++) txn(1'b1, 1'b0, 2'b01, 32'h10 + 32'(i), 32'h0, 1'b0);
    txn(1'b1, 1'b0, 2'b10, 32'h10, 32'h0, 1'b0);
    txn(1'b1, 1'b0, 2'b10, 32'h12, 32'h0, 1'b0);
    txn(1'b1, 1'b0, 2'b00, 32'h10, 32'h0, 1'b0);

    // Sub-word stores via read-modify-write
    preload(4, 32'h1122_3344);
    txn(1'b0, 1'b1, 2'b01, 32'h11, 32'h0000_00AB, 1'b0);
    chk("sb_result", mem0[4], 32'h1122_AB44);
    txn(1'b0, 1'b1, 2'b10, 32'h12, 32'h0000_BEEF, 1'b0);
    chk("sh_result", mem0[4], 32'hBEEF_AB44);

    // Misaligned requests
    txn(1'b1, 1'b0, 2'b00, 32'h02, 32'h0, 1'b0);
    txn(1'b1, 1'b0, 2'b10, 32'h03, 32'h0, 1'b0);

    // Word store with stray read pulse while busy
    txn(1'b0, 1'b1, 2'b00, 32'h20, 32'hDEAD_BEEF, 1'b1);
    chk("sw_word8_w3", mem3[8], 32'hDEAD_BEEF);

    // Reset during RMW read of a byte store
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b01, 32'h11, 32'h0000_005A);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    chk("rmw_rd_active", {31'b0, ram_en0}, 32'd1);
    r0s = rdy0; r3s = rdy3; w0s = we0; w3s = we3;
    rst_n = 1'b0;
    #1;
    chk("abort_ram_we_w0", {31'b0, ram_we0}, 32'd0);
    chk("abort_ram_we_w3", {31'b0, ram_we3}, 32'd0);
    chk("abort_busy_w0", {31'b0, bus0.busy}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_ready_w0", 32'(rdy0 - r0s), 32'd0);
    chk("abort_no_ready_w3", 32'(rdy3 - r3s), 32'd0);
    chk("abort_no_write_w0", 32'(we0 - w0s), 32'd0);
    chk("abort_no_write_w3", 32'(we3 - w3s), 32'd0);
    chk("abort_word_w0", mem0[4], ref_mem[4]);
    chk("abort_word_w3", mem3[4], ref_mem[4]);
    txn(1'b1, 1'b0, 2'b00, 32'h10, 32'h0, 1'b0);

    // Randomized traffic; mem_write wins when both strobes are set
    for (int n = 0; n < 60; n++) begin
      rd = 1'($urandom());
      wr = 1'($urandom());
      if (!rd && !wr) rd = 1'b1;
      sz = 2'($urandom());
      hi = $urandom() & 32'hFFFF_F000;
      a  = hi | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
      txn(rd, wr, sz, a, $urandom(), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
